// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, framed as start bit,
// DATA_BITS data bits LSB first, optional parity bit, and one or two stop bits.
module uart_tx_frame #(
    parameter int CLK_HZ    = 10_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    // Width guarded so an illegal baud setting reaches the error below rather than a zero-width vector.
    localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_frame: CLK_HZ / BAUD must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cyc_reg, cyc_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_reg, par_next;
    logic                 tx_reg, tx_next;
    logic                 bit_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        bit_done   = (cyc_reg == CNT_LAST);
        if (bit_done) begin
            cyc_next = '0;
        end

        case (state_reg)
            IDLE: begin
                cyc_next = '0;
                if (tx_valid) begin
                    shift_next = tx_data;
                    par_next   = (PARITY == 1) ? ~(^tx_data) : ^tx_data;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_reg == DATA_LAST) begin
                        state_next = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            PAR: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // The bit counter tallies stop bits so the cycle counter stays one bit period wide.
                if (bit_done) begin
                    if (bit_reg == STOP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg) begin
            cyc_next = '0;
            bit_next = '0;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PAR:     tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign tx       = tx_reg;
    assign busy     = (state_reg != IDLE);
    assign tx_ready = (state_reg == IDLE) && !rst;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised scoreboard bench for uart_tx_frame across four frame formats
// (8N1, 8E1, 8O1, 7N2) at 10 clocks per bit.
module tb_uart_tx_frame;
    localparam int CPB = 10;

    typedef struct packed {
        logic [8:0] data;
        logic       b2b;
    } exp_t;

    logic clk;
    int   cyc;
    int   checks;
    int   errors;

    initial begin
        clk    = 1'b0;
        cyc    = 0;
        checks = 0;
        errors = 0;
    end
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cfg
            localparam int DB  = (gi == 3) ? 7 : 8;
            localparam int PAR = (gi == 1) ? 2 : ((gi == 2) ? 1 : 0);
            localparam int SB  = (gi == 3) ? 2 : 1;

            logic          rst;
            logic [DB-1:0] tx_data;
            logic          tx_valid;
            logic          tx_ready;
            logic          tx;
            logic          busy;
            logic          mon_en;
            logic          done;
            logic          prev_hold;
            int            last_idle;
            exp_t          q[$];

            uart_tx_frame #(
                .CLK_HZ   (1_000_000),
                .BAUD     (100_000),
                .DATA_BITS(DB),
                .PARITY   (PAR),
                .STOP_BITS(SB)
            ) u_dut (
                .clk     (clk),
                .rst     (rst),
                .tx_data (tx_data),
                .tx_valid(tx_valid),
                .tx_ready(tx_ready),
                .tx      (tx),
                .busy    (busy)
            );

            task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL inst%0d %s got=%0h exp=%0h", gi, name, got, want);
                end
            endtask

            task automatic wait_ready();
                int n;
                n = 0;
                @(negedge clk);
                while (tx_ready !== 1'b1 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                if (tx_ready !== 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL inst%0d ready_timeout got=%0b exp=1", gi, tx_ready);
                end
            endtask

            // hold keeps tx_valid high through the frame so the next word goes back-to-back.
            task automatic send(input logic [8:0] w, input logic hold);
                logic [8:0] m;
                m = 9'((1 << DB) - 1);
                if (!prev_hold) begin
                    repeat ($urandom_range(0, 15)) @(negedge clk);
                end
                wait_ready();
                tx_data  = DB'(w);
                tx_valid = 1'b1;
                q.push_back('{data: w & m, b2b: prev_hold});
                @(posedge clk);
                #1;
                tx_data = DB'($urandom);
                if (!hold) begin
                    tx_valid = 1'b0;
                end
                prev_hold = hold;
            endtask

            // Driver
            initial begin
                int bad;
                rst       = 1'b1;
                tx_data   = '0;
                tx_valid  = 1'b0;
                mon_en    = 1'b0;
                done      = 1'b0;
                prev_hold = 1'b0;
                repeat (3) @(negedge clk);
                chk("reset_tx", tx, 1);
                chk("reset_busy", busy, 0);
                chk("reset_ready", tx_ready, 0);
                rst = 1'b0;
                #1;
                chk("ready_after_reset", tx_ready, 1);

                if (gi == 0) begin
                    wait_ready();
                    tx_data  = DB'(9'h05A);
                    tx_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    tx_valid = 1'b0;
                    repeat (35) @(negedge clk);
                    chk("busy_mid_frame", busy, 1);
                    rst = 1'b1;
                    #1;
                    chk("ready_in_rst", tx_ready, 0);
                    @(negedge clk);
                    chk("tx_after_rst", tx, 1);
                    chk("busy_after_rst", busy, 0);
                    rst = 1'b0;
                    #1;
                    chk("ready_rst_release", tx_ready, 1);
                end
                mon_en = 1'b1;

                case (gi)
                    0: begin
                        send(9'h03C, 1'b0);
                        send(9'h0A5, 1'b0);
                        send(9'h000, 1'b1);
                        send(9'h0FF, 1'b0);
                    end
                    1: begin
                        send(9'h007, 1'b0);
                        send(9'h000, 1'b0);
                    end
                    2: send(9'h007, 1'b0);
                    default: send(9'h0C1, 1'b0);
                endcase

                for (int i = 0; i < 6; i++) begin
                    send(9'($urandom), (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0);
                end

                wait_ready();
                bad = 0;
                for (int i = 0; i < 500; i++) begin
                    @(negedge clk);
                    if (tx !== 1'b1 || busy !== 1'b0) bad++;
                end
                chk("idle_500_bad_cycles", bad, 0);
                chk("queue_empty", q.size(), 0);
                done = 1'b1;
            end

            // Monitor: rebuilds each expected frame from the accepted word and checks every cycle.
            initial begin
                exp_t        e;
                logic [15:0] expf;
                logic [15:0] got;
                int          nb;
                int          bad;
                int          start;
                int          p;
                int          n;
                last_idle = -10;
                forever begin
                    @(negedge clk);
                    if (mon_en && tx === 1'b0) begin
                        start = cyc;
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL inst%0d unexpected_frame got=start_bit exp=idle", gi);
                            n = 0;
                            while (busy === 1'b1 && n < 300) begin
                                @(negedge clk);
                                n++;
                            end
                        end else begin
                            e    = q.pop_front();
                            p    = $countones(e.data) % 2;
                            expf = '1;
                            expf[0] = 1'b0;
                            for (int i = 0; i < DB; i++) expf[1 + i] = e.data[i];
                            if (PAR == 2) expf[1 + DB] = p[0];
                            if (PAR == 1) expf[1 + DB] = ~p[0];
                            nb = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
                            if (e.b2b) chk("b2b_start_gap", start - last_idle, 1);
                            bad = 0;
                            got = '1;
                            for (int k = 0; k < nb * CPB; k++) begin
                                if (k > 0) @(negedge clk);
                                if (tx !== expf[k / CPB] || busy !== 1'b1) bad++;
                                if (k % CPB == CPB / 2) got[k / CPB] = tx;
                            end
                            @(negedge clk);
                            last_idle = cyc;
                            chk("frame_end_idle", {29'd0, tx_ready, tx, busy}, 32'b110);
                            chk("frame_bits", got, expf);
                            chk("frame_bad_cycles", bad, 0);
                            $display("inst%0d frame data=%0h b2b=%0b bits=%b len=%0d", gi, e.data, e.b2b,
                                     got, nb * CPB);
                        end
                    end
                end
            end
        end
    endgenerate

    initial begin
        int n;
        n = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done)) begin
            checks++;
            errors++;
            $display("FAIL global_timeout got=%0d cycles exp=all drivers done", n);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
